// File: rtl/booth_r4_seq_mul_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier: FSM states, recoded
// digit operations and the Booth recoder.
package booth_r4_seq_mul_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StExec = 2'b01,
      StDone = 2'b10
   } state_e;

   typedef enum logic [2:0] {
      Br4Zero,
      Br4P1,
      Br4P2,
      Br4M1,
      Br4M2
   } booth_op_e;

   // Recode {L[1], L[0], q_m1} into the addend selection.
   function automatic booth_op_e booth_decode(input logic [2:0] code);
      booth_op_e op;
      case (code)
         3'b001, 3'b010: op = Br4P1;
         3'b011:         op = Br4P2;
         3'b100:         op = Br4M2;
         3'b101, 3'b110: op = Br4M1;
         default:        op = Br4Zero;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/booth_r4_seq_mul_if.sv
// Start/busy/done handshake and operand/result bus of the Booth multiplier.
interface booth_r4_seq_mul_if #(
   parameter int unsigned WIDTH = 64
);
   logic                 start;
   logic                 clear;
   logic                 signed_mode;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   result;

   modport master (
      output start, clear, signed_mode, multiplicand, multiplier,
      input  busy, done, result
   );

   modport slave (
      input  start, clear, signed_mode, multiplicand, multiplier,
      output busy, done, result
   );
endinterface

// File: rtl/booth_r4_seq_mul_step.sv
// One radix-4 Booth step: recode, add the selected multiple of M to H, then
// arithmetic-shift {H', L, q_m1} right by two.
module booth_r4_seq_mul_step
   import booth_r4_seq_mul_pkg::*;
#(
   parameter int unsigned EW = 66
) (
   input  logic [EW+1:0] h,
   input  logic [EW-1:0] l,
   input  logic          q_m1,
   input  logic [EW+1:0] m_ext,
   output logic [EW+1:0] h_nxt,
   output logic [EW-1:0] l_nxt,
   output logic          q_m1_nxt
);

   booth_op_e     op;
   logic [EW+1:0] addend;
   logic          cin;
   logic [EW+1:0] sum;

   always_comb begin
      op     = booth_decode({l[1:0], q_m1});
      addend = '0;
      cin    = 1'b0;
      // Negative digits use the inverted multiple plus a carry-in.
      case (op)
         Br4P1: addend = m_ext;
         Br4P2: addend = {m_ext[EW:0], 1'b0};
         Br4M1: begin
            addend = ~m_ext;
            cin    = 1'b1;
         end
         Br4M2: begin
            addend = ~{m_ext[EW:0], 1'b0};
            cin    = 1'b1;
         end
         default: addend = '0;
      endcase
      sum      = h + addend + {{(EW+1){1'b0}}, cin};
      h_nxt    = {{2{sum[EW+1]}}, sum[EW+1:2]};
      l_nxt    = {sum[1:0], l[EW-1:2]};
      q_m1_nxt = l[1];
   end

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Iterative radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, one digit per
// clock, signed or unsigned, behind a start/busy/done handshake.
module booth_r4_seq_mul
   import booth_r4_seq_mul_pkg::*;
#(
   parameter int unsigned WIDTH = 64
) (
   input logic               clk,
   input logic               reset_n,
   booth_r4_seq_mul_if.slave bus
);

   localparam int unsigned EW    = WIDTH + 2;
   localparam int unsigned N     = EW / 2;
   localparam int unsigned CNT_W = $clog2(WIDTH / 2 + 2);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [EW+1:0]      h_q, h_d;
   logic [EW-1:0]      l_q, l_d;
   logic               qm1_q, qm1_d;
   logic [EW+1:0]      m_q, m_d;
   logic [2*WIDTH-1:0] result_q, result_d;

   logic [EW+1:0]      h_step;
   logic [EW-1:0]      l_step;
   logic               qm1_step;
   logic               sext_m, sext_q, launch;

   booth_r4_seq_mul_step #(
      .EW (EW)
   ) u_step (
      .h        (h_q),
      .l        (l_q),
      .q_m1     (qm1_q),
      .m_ext    (m_q),
      .h_nxt    (h_step),
      .l_nxt    (l_step),
      .q_m1_nxt (qm1_step)
   );

   assign sext_m = bus.signed_mode & bus.multiplicand[WIDTH-1];
   assign sext_q = bus.signed_mode & bus.multiplier[WIDTH-1];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      h_d      = h_q;
      l_d      = l_q;
      qm1_d    = qm1_q;
      m_d      = m_q;
      result_d = result_q;
      launch   = 1'b0;

      case (state_q)
         StExec: begin
            if (bus.clear) begin
               state_d = StIdle;
            end else begin
               h_d   = h_step;
               l_d   = l_step;
               qm1_d = qm1_step;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(N - 1)) begin
                  // Low 2*WIDTH bits of {H, L} after the final step.
                  result_d = {h_step[WIDTH-3:0], l_step};
                  state_d  = StDone;
               end
            end
         end
         StDone: begin
            if (bus.clear) begin
               state_d = StIdle;
            end else if (bus.start) begin
               launch = 1'b1;
            end
         end
         default: begin
            // Covers StIdle and the unused encoding 2'b11.
            state_d = StIdle;
            if (bus.start && !bus.clear) begin
               launch = 1'b1;
            end
         end
      endcase

      if (launch) begin
         state_d = StExec;
         cnt_d   = '0;
         h_d     = '0;
         l_d     = {{2{sext_q}}, bus.multiplier};
         qm1_d   = 1'b0;
         m_d     = {{4{sext_m}}, bus.multiplicand};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         h_q      <= '0;
         l_q      <= '0;
         qm1_q    <= 1'b0;
         m_q      <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         h_q      <= h_d;
         l_q      <= l_d;
         qm1_q    <= qm1_d;
         m_q      <= m_d;
         result_q <= result_d;
      end
   end

   assign bus.busy   = (state_q == StExec);
   assign bus.done   = (state_q == StDone);
   assign bus.result = result_q;

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Directed and random checks of booth_r4_seq_mul at WIDTH=8 and WIDTH=64.
module tb_booth_r4_seq_mul;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   booth_r4_seq_mul_if #(.WIDTH(8))  bus8 ();
   booth_r4_seq_mul_if #(.WIDTH(64)) bus64 ();

   booth_r4_seq_mul #(.WIDTH(8)) dut8 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus8)
   );

   booth_r4_seq_mul #(.WIDTH(64)) dut64 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus64)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        sm;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp;
   } vec8_t;

   vec8_t vt[10];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic launch8(input logic sm, input logic [7:0] a, input logic [7:0] b);
      bus8.signed_mode  = sm;
      bus8.multiplicand = a;
      bus8.multiplier   = b;
      bus8.start        = 1'b1;
      @(posedge clk); #1;
      bus8.start        = 1'b0;
      bus8.signed_mode  = ~sm;
      bus8.multiplicand = ~a;
      bus8.multiplier   = ~b;
   endtask

   task automatic wait_done8(input int lat0, output int lat);
      lat = lat0;
      while (bus8.done !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic launch64(input logic sm, input logic [63:0] a, input logic [63:0] b);
      bus64.signed_mode  = sm;
      bus64.multiplicand = a;
      bus64.multiplier   = b;
      bus64.start        = 1'b1;
      @(posedge clk); #1;
      bus64.start        = 1'b0;
      bus64.signed_mode  = ~sm;
      bus64.multiplicand = ~a;
      bus64.multiplier   = ~b;
   endtask

   task automatic wait_done64(output int lat);
      lat = 0;
      while (bus64.done !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      int lat;
      logic [7:0] ra, rb;
      logic sm;
      logic signed [15:0] sa16, sb16;
      logic [15:0] e16;
      logic [63:0] a64, b64;
      logic signed [127:0] sa128, sb128;
      logic [127:0] e128;

      vt[0] = '{1'b1, 8'h80, 8'h80, 16'h4000};
      vt[1] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
      vt[2] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
      vt[3] = '{1'b1, 8'h7F, 8'hFF, 16'hFF81};
      vt[4] = '{1'b0, 8'h00, 8'h55, 16'h0000};
      vt[5] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
      vt[6] = '{1'b0, 8'h80, 8'h02, 16'h0100};
      vt[7] = '{1'b1, 8'h03, 8'hFD, 16'hFFF7};
      vt[8] = '{1'b0, 8'h0F, 8'h11, 16'h00FF};
      vt[9] = '{1'b1, 8'h01, 8'h80, 16'hFF80};

      bus8.start = 0;  bus8.clear = 0;  bus8.signed_mode = 0;
      bus8.multiplicand = 0;  bus8.multiplier = 0;
      bus64.start = 0; bus64.clear = 0; bus64.signed_mode = 0;
      bus64.multiplicand = 0; bus64.multiplier = 0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy8", 128'(bus8.busy), 128'd0);
      chk("reset_done8", 128'(bus8.done), 128'd0);
      chk("reset_result8", 128'(bus8.result), 128'd0);
      chk("reset_busy64", 128'(bus64.busy), 128'd0);
      chk("reset_result64", bus64.result, 128'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // clear wins over start in IDLE
      bus8.clear = 1'b1;
      bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.clear = 1'b0;
      bus8.start = 1'b0;
      chk("idle_clear_start_busy", 128'(bus8.busy), 128'd0);

      // Table: every start after the first is issued from DONE
      for (int i = 0; i < 10; i++) begin
         launch8(vt[i].sm, vt[i].a, vt[i].b);
         chk($sformatf("vec%0d_busy", i), 128'(bus8.busy), 128'd1);
         chk($sformatf("vec%0d_done_low", i), 128'(bus8.done), 128'd0);
         wait_done8(0, lat);
         chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd5);
         chk($sformatf("vec%0d_result", i), 128'(bus8.result), 128'(vt[i].exp));
      end

      // start pulse during EXEC is ignored
      launch8(1'b0, 8'd3, 8'd5);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus8.start = 1'b1;
      bus8.signed_mode = 1'b0;
      bus8.multiplicand = 8'd7;
      bus8.multiplier = 8'd7;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      wait_done8(3, lat);
      chk("exec_start_latency", 128'(lat), 128'd5);
      chk("exec_start_result", 128'(bus8.result), 128'd15);

      // clear mid-EXEC keeps the prior result
      launch8(1'b1, 8'hFF, 8'hFF);
      wait_done8(0, lat);
      chk("prior_result", 128'(bus8.result), 128'h0001);
      launch8(1'b0, 8'd3, 8'd5);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus8.clear = 1'b1;
      @(posedge clk); #1;
      bus8.clear = 1'b0;
      chk("exec_clear_busy", 128'(bus8.busy), 128'd0);
      chk("exec_clear_done", 128'(bus8.done), 128'd0);
      chk("exec_clear_result", 128'(bus8.result), 128'h0001);
      repeat (6) @(posedge clk);
      #1;
      chk("exec_clear_stays_idle", 128'(bus8.done), 128'd0);

      // clear has priority over start in DONE
      launch8(1'b1, 8'd2, 8'd3);
      wait_done8(0, lat);
      chk("done_result", 128'(bus8.result), 128'd6);
      bus8.clear = 1'b1;
      bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.clear = 1'b0;
      bus8.start = 1'b0;
      chk("done_clear_busy", 128'(bus8.busy), 128'd0);
      chk("done_clear_done", 128'(bus8.done), 128'd0);
      chk("done_clear_result", 128'(bus8.result), 128'd6);

      // Asynchronous reset mid-EXEC
      launch8(1'b1, 8'h80, 8'h80);
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_busy", 128'(bus8.busy), 128'd0);
      chk("async_rst_done", 128'(bus8.done), 128'd0);
      chk("async_rst_result", 128'(bus8.result), 128'd0);
      #2 reset_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_idle", 128'(bus8.busy), 128'd0);
      launch8(1'b1, 8'hF9, 8'h06);
      wait_done8(0, lat);
      chk("post_rst_latency", 128'(lat), 128'd5);
      chk("post_rst_result", 128'(bus8.result), 128'hFFD6);

      for (int i = 0; i < 200; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         sm = 1'($urandom);
         sa16 = $signed(ra);
         sb16 = $signed(rb);
         e16 = sm ? 16'(sa16 * sb16) : 16'({8'd0, ra} * {8'd0, rb});
         launch8(sm, ra, rb);
         wait_done8(0, lat);
         chk($sformatf("rand8_%0d %0d*%0d sm=%0d", i, ra, rb, sm), 128'(bus8.result), 128'(e16));
      end

      launch64(1'b0, '1, '1);
      wait_done64(lat);
      chk("w64_latency", 128'(lat), 128'd33);
      chk("w64_ones", bus64.result, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

      for (int i = 0; i < 500; i++) begin
         a64 = {$urandom, $urandom};
         b64 = {$urandom, $urandom};
         sm = 1'($urandom);
         sa128 = $signed(a64);
         sb128 = $signed(b64);
         e128 = sm ? 128'(sa128 * sb128) : 128'({64'd0, a64} * {64'd0, b64});
         launch64(sm, a64, b64);
         wait_done64(lat);
         chk($sformatf("rand64_%0d sm=%0d", i, sm), bus64.result, e128);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
